// File: rtl/fereduce.sv
// Sequential reducer: folds a 510-bit value modulo p = 2^255-19 into its canonical residue.
// Uses a limb-serial first fold, a single-cycle second fold and one conditional subtraction.
module fereduce #(
    parameter int LIMB = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [509:0] in,
    output logic         done,
    output logic         busy,
    output logic [254:0] out
);

    localparam int NLIMB = 256 / LIMB;
    localparam int KW    = $clog2(NLIMB);
    localparam int AW    = LIMB + 5;
    localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FOLD1 = 3'd1;
    localparam logic [2:0] S_FOLD2 = 3'd2;
    localparam logic [2:0] S_CSUB  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [255:0]    hi_q, hi_d;
    logic [255:0]    lo_q, lo_d;
    logic [4:0]      carry_q, carry_d;
    logic [255:0]    x2_q, x2_d;
    logic [254:0]    out_q, out_d;

    logic [255:0]    x1_flat;
    logic [LIMB-1:0] lo_sel;
    logic [LIMB-1:0] hi_sel;
    logic [AW-1:0]   acc;
    logic            fold1_en;
    logic [10:0]     fold_add;
    logic            ge_p;
    logic [254:0]    x2_minus_p;

    assign fold1_en = (state_q == S_FOLD1);
    assign lo_sel   = lo_q[k_q*LIMB +: LIMB];
    assign hi_sel   = hi_q[k_q*LIMB +: LIMB];

    // 2^255 == 19 (mod p): each high limb is weighted by 19 against its low partner.
    assign acc = AW'(lo_sel) + AW'(hi_sel) * AW'(19) + AW'(carry_q);

    // Bits of x1 from 255 upward are the final carry plus bit 255 of the limb store.
    assign fold_add = 11'({carry_q, x1_flat[255]}) * 11'd19;

    // x2 < 2p, so modulo-2^255 subtraction is exact whenever it is selected.
    assign ge_p       = (x2_q >= P);
    assign x2_minus_p = x2_q[254:0] - P[254:0];

    genvar gi;
    generate
        for (gi = 0; gi < NLIMB; gi++) begin : g_x1
            logic [LIMB-1:0] x1_limb_q;
            logic [LIMB-1:0] x1_limb_d;

            assign x1_limb_d = (fold1_en && (k_q == KW'(gi))) ? acc[LIMB-1:0] : x1_limb_q;
            assign x1_flat[gi*LIMB +: LIMB] = x1_limb_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    x1_limb_q <= '0;
                end else begin
                    x1_limb_q <= x1_limb_d;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        carry_d = carry_q;
        x2_d    = x2_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hi_d    = {1'b0, in[509:255]};
                    lo_d    = {1'b0, in[254:0]};
                    carry_d = '0;
                    k_d     = '0;
                    state_d = S_FOLD1;
                end
            end
            S_FOLD1: begin
                carry_d = acc[AW-1:LIMB];
                k_d     = k_q + 1'b1;
                if (k_q == KW'(NLIMB - 1)) begin
                    state_d = S_FOLD2;
                end
            end
            S_FOLD2: begin
                x2_d    = {1'b0, x1_flat[254:0]} + 256'(fold_add);
                state_d = S_CSUB;
            end
            S_CSUB: begin
                out_d   = ge_p ? x2_minus_p : x2_q[254:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            carry_q <= '0;
            x2_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            carry_q <= carry_d;
            x2_q    <= x2_d;
            out_q   <= out_d;
        end
    end

    assign done = (state_q == S_DONE);
    assign busy = (state_q != S_IDLE);
    assign out  = out_q;

endmodule

// File: tb/tb_fereduce.sv
// Self-checking bench for fereduce: fixed vectors, multi-cycle corner sequences and
// random inputs compared against a plain bignum modulo model.
module tb_fereduce;

    localparam logic [255:0] P256   = (256'd1 << 255) - 256'd19;
    localparam logic [254:0] P      = P256[254:0];
    localparam logic [509:0] PW     = {255'd0, P};
    localparam logic [509:0] TWO255 = 510'(1) << 255;
    localparam logic [509:0] TWO509 = 510'(1) << 509;
    localparam logic [509:0] ALL1   = ~510'd0;

    typedef struct {
        logic [509:0] din;
        logic [254:0] exp;
        string        nm;
    } vec_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [509:0] din;
    logic         done;
    logic         busy;
    logic [254:0] dout;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    fereduce #(.LIMB(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .in    (din),
        .done  (done),
        .busy  (busy),
        .out   (dout)
    );

    always #5 clock = ~clock;

    function automatic logic [254:0] ref_mod(input logic [509:0] v);
        return 255'(v % PW);
    endfunction

    function automatic logic [509:0] rand510();
        logic [511:0] t;
        for (int i = 0; i < 16; i++) t[i*32 +: 32] = $urandom();
        return t[509:0];
    endfunction

    task automatic check(input string nm, input logic [509:0] act, input logic [509:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Called 1 time unit after an edge with the DUT idle; returns likewise, back in IDLE.
    task automatic run_op(input logic [509:0] v, input bit noise,
                          output logic [254:0] res, output int lat);
        int n;
        din   = v;
        start = 1'b1;
        lat   = -1;
        @(posedge clock); #1;
        n = 1;
        check("busy_rise", 510'(busy), 510'(1));
        start = 1'b0;
        while (!done && n < 30) begin
            if (noise) begin
                start = 1'($urandom());
                din   = rand510();
            end
            @(posedge clock); #1;
            n++;
        end
        if (done) lat = n;
        res   = dout;
        start = 1'b0;
        @(posedge clock); #1;
        check("done_pulse", 510'(done), 510'(0));
        check("busy_fall", 510'(busy), 510'(0));
        txn++;
        $display("txn %0d in=%0h out=%0h lat=%0d", txn, v, res, lat);
    endtask

    initial begin
        vec_t         tbl[9];
        logic [254:0] res;
        logic [254:0] o1, o2;
        logic [509:0] v;
        int           lat, d1, d2, mode;
        bit           seen;

        tbl[0].din = TWO255;            tbl[0].exp = 255'd19;          tbl[0].nm = "two255";
        tbl[1].din = PW;                tbl[1].exp = 255'd0;           tbl[1].nm = "p";
        tbl[2].din = PW - 510'd1;       tbl[2].exp = P - 255'd1;       tbl[2].nm = "p_minus_1";
        tbl[3].din = TWO255 - 510'd1;   tbl[3].exp = 255'd18;          tbl[3].nm = "two255_m1";
        tbl[4].din = ALL1;              tbl[4].exp = 255'd360;         tbl[4].nm = "all_ones";
        tbl[5].din = (PW - 510'd1) * (PW - 510'd1);
                                        tbl[5].exp = 255'd1;           tbl[5].nm = "pm1_sq";
        tbl[6].din = TWO509;            tbl[6].exp = ref_mod(TWO509);  tbl[6].nm = "two509";
        tbl[7].din = PW + 510'd5;       tbl[7].exp = 255'd5;           tbl[7].nm = "p_plus_5";
        tbl[8].din = PW + PW;           tbl[8].exp = 255'd0;           tbl[8].nm = "two_p";

        reset = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_done", 510'(done), 510'(0));
        check("rst_busy", 510'(busy), 510'(0));
        check("rst_out", 510'(dout), 510'(0));

        // Reset must win over a simultaneous start.
        start = 1'b1;
        din   = TWO255;
        @(posedge clock); #1;
        check("rst_vs_start", 510'(busy), 510'(0));
        reset = 1'b0;
        start = 1'b0;

        run_op('0, 1'b0, res, lat);
        check("zero_out", 510'(res), 510'(0));
        check("zero_lat", 510'(lat), 510'(11));

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].din, 1'b0, res, lat);
            check({tbl[i].nm, "_out"}, 510'(res), 510'(tbl[i].exp));
            check({tbl[i].nm, "_lat"}, 510'(lat), 510'(11));
        end

        // Back-to-back with start held high; in changes after the first accept.
        d1    = -1;
        d2    = -1;
        o1    = '0;
        o2    = '0;
        din   = TWO255;
        start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock); #1;
            if (n == 1) din = ALL1;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    o1 = dout;
                end else if (d2 < 0) begin
                    d2    = n;
                    o2    = dout;
                    start = 1'b0;
                end
            end
        end
        check("b2b_first_lat", 510'(d1), 510'(11));
        check("b2b_spacing", 510'(d2 - d1), 510'(12));
        check("b2b_out1", 510'(o1), 510'(19));
        check("b2b_out2", 510'(o2), 510'(360));
        check("b2b_idle", 510'(busy), 510'(0));
        txn++;
        $display("txn %0d back_to_back out1=%0h out2=%0h gap=%0d", txn, o1, o2, d2 - d1);

        // Reset during FOLD1 limb 4 discards the operation.
        din   = ALL1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_busy", 510'(busy), 510'(0));
        check("midrst_done", 510'(done), 510'(0));
        check("midrst_out", 510'(dout), 510'(0));
        reset = 1'b0;
        seen  = 1'b0;
        repeat (15) begin
            @(posedge clock); #1;
            if (done || busy) seen = 1'b1;
        end
        check("midrst_quiet", 510'(seen), 510'(0));
        txn++;
        $display("txn %0d mid_reset quiet=%0d", txn, !seen);
        run_op(TWO255, 1'b0, res, lat);
        check("after_rst_out", 510'(res), 510'(19));
        check("after_rst_lat", 510'(lat), 510'(11));

        for (int i = 0; i < 1000; i++) begin
            mode = $urandom_range(0, 3);
            v    = rand510();
            case (mode)
                1:       v = v >> $urandom_range(0, 509);
                2:       v = PW + 510'($urandom_range(0, 40));
                3:       v = ~(v & rand510() & rand510());
                default: v = v;
            endcase
            run_op(v, i[0], res, lat);
            check("rand_out", 510'(res), 510'(ref_mod(v)));
            check("rand_lt_p", 510'(res < P), 510'(1));
            check("rand_lat", 510'(lat), 510'(11));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
